// File: rtl/cram_loader.sv
// Boot loader: receives a big-endian length-prefixed byte stream and writes it word by word into CRAM.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module cram_loader #(
    parameter int DATA_W      = 32,
    parameter int CRAM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic                   i_ready,
    output logic                   cram_we,
    output logic [CRAM_ADDR_W-1:0] cram_waddr,
    output logic [DATA_W-1:0]      cram_wdata,
    output logic                   core_nrst,
    output logic                   load_err
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,S_CSUM = 3'd5
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t TERM_STATE = S_CSUM;
`else
    localparam state_t TERM_STATE = S_DONE;
`endif

    localparam logic [31:0] DEPTH = 32'd1 << CRAM_ADDR_W;

    state_t                 state_r;
    state_t                 state_n;
    logic [1:0]             byte_cnt_r;
    logic [23:0]            shift_r;
    logic [CRAM_ADDR_W:0]   addr_r;
    logic [CRAM_ADDR_W:0]   n_r;
    logic                   i_ready_r;
    logic                   cram_we_r;
    logic [CRAM_ADDR_W-1:0] cram_waddr_r;
    logic [DATA_W-1:0]      cram_wdata_r;
    logic                   core_nrst_r;
    logic                   load_err_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum_r;
`endif

    logic                   accept_s;
    logic                   last_byte_s;
    logic [31:0]            word_s;
    logic [CRAM_ADDR_W:0]   addr_inc_s;
    logic                   last_word_s;

    assign accept_s    = i_valid & i_ready_r;
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign word_s      = {shift_r, i_data};
    assign addr_inc_s  = addr_r + {{CRAM_ADDR_W{1'b0}}, 1'b1};
    // The counter is one bit wider than the CRAM address so a full-depth load ends without wrapping.
    assign last_word_s = (addr_inc_s == n_r);

    assign i_ready    = i_ready_r;
    assign cram_we    = cram_we_r;
    assign cram_waddr = cram_waddr_r;
    assign cram_wdata = cram_wdata_r;
    assign core_nrst  = core_nrst_r;
    assign load_err   = load_err_r;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= S_LEN;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_LEN: begin
                if (accept_s && last_byte_s) begin
                    if (word_s == 32'd0) begin
                        state_n = TERM_STATE;
                    end else if (word_s > DEPTH) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_DATA;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            S_DATA: begin
                if (accept_s && last_byte_s) begin
                    state_n = S_WRITE;
                end else begin
                    state_n = state_r;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
                    state_n = TERM_STATE;
                end else begin
                    state_n = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    if (i_data == csum_r) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ERR;
                    end
                end else begin
                    state_n = state_r;
                end
            end
`endif
            S_DONE:  state_n = S_DONE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // Datapath and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= 24'd0;
            addr_r       <= '0;
            n_r          <= '0;
            i_ready_r    <= 1'b0;
            cram_we_r    <= 1'b0;
            cram_waddr_r <= '0;
            cram_wdata_r <= '0;
            core_nrst_r  <= 1'b0;
            load_err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
        end else begin
            i_ready_r   <= (state_n != S_WRITE) && (state_n != S_DONE);
            cram_we_r   <= (state_n == S_WRITE);
            core_nrst_r <= (state_n == S_DONE);
            load_err_r  <= (state_n == S_ERR);
            if (accept_s && ((state_r == S_LEN) || (state_r == S_DATA))) begin
                shift_r    <= word_s[23:0];
                byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum_r     <= csum_r ^ i_data;
`endif
            end
            if ((state_r == S_LEN) && (state_n == S_DATA)) begin
                addr_r <= '0;
                n_r    <= word_s[CRAM_ADDR_W:0];
            end
            if ((state_r == S_DATA) && (state_n == S_WRITE)) begin
                cram_waddr_r <= addr_r[CRAM_ADDR_W-1:0];
                cram_wdata_r <= word_s;
            end
            if (state_r == S_WRITE) begin
                addr_r <= addr_inc_s;
            end
        end
    end

endmodule
